// File: rtl/clock_mode_ctrl.sv
// Mode and time-base controller for the digital clock: derives counter increment
// pulses from the 1 Hz divider clock and runs the button-driven time-setting FSM.
module clock_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int HOLD_TICKS      = 2,
    parameter int TIMEOUT_TICKS   = 30
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       div_clk,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_at_max,
    input  logic       min_at_max,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       hr_inc,
    output logic       sec_clr,
    output logic [1:0] mode,
    output logic       blink_hr,
    output logic       blink_min
);

    localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
    localparam int IDLE_W = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_TICKS);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    // ---------------------------------------------------------------- tick
    logic div_d1;
    logic div_d2;
    logic tick;

    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from values sampled at the same edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            div_d1 <= 1'b0;
            div_d2 <= 1'b0;
        end else begin
            div_d1 <= div_clk;
            div_d2 <= div_d1;
        end
    end

    assign tick = div_d1 & ~div_d2;

    // ------------------------------------------------------- button paths
    // Index 0 is the mode button, index 1 the increment button.
    logic [1:0]      btn_raw;
    logic [1:0]      sync1;
    logic [1:0]      sync2;
    logic [1:0]      level;
    logic [1:0]      level_q;
    logic [1:0]      press;
    logic [DB_W-1:0] db_cnt [2];

    assign btn_raw = {btn_inc, btn_mode};

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                sync1[i]   <= 1'b0;
                sync2[i]   <= 1'b0;
                level[i]   <= 1'b0;
                level_q[i] <= 1'b0;
                db_cnt[i]  <= '0;
            end else begin
                sync1[i]   <= btn_raw[i];
                sync2[i]   <= sync1[i];
                level_q[i] <= level[i];
                // Any sample that agrees with the accepted level restarts the count.
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = level & ~level_q;

    logic mode_press;
    logic inc_press;
    logic inc_level;

    assign mode_press = press[0];
    assign inc_press  = press[1];
    assign inc_level  = level[1];

    // -------------------------------------------------- next-state logic
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_next;
    logic              rpt;
    logic              inc_evt;
    logic              timeout;
    logic              sec_inc_next;
    logic              min_inc_next;
    logic              hr_inc_next;
    logic              sec_clr_next;

    // NOTE: every signal gets a default before the case statement, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        sec_inc_next = 1'b0;
        min_inc_next = 1'b0;
        hr_inc_next  = 1'b0;
        sec_clr_next = 1'b0;
        rpt          = 1'b0;
        inc_evt      = 1'b0;
        timeout      = 1'b0;

        case (state)
            ST_RUN: begin
                if (tick) begin
                    sec_inc_next = 1'b1;
                    min_inc_next = sec_at_max;
                    hr_inc_next  = sec_at_max & min_at_max;
                end
                if (mode_press) begin
                    state_next = ST_SET_HR;
                end
            end
            ST_SET_HR, ST_SET_MIN: begin
                rpt     = tick & inc_level & (hold_cnt == HOLD_MAX);
                inc_evt = inc_press | rpt;
                timeout = tick & ~inc_evt & (idle_cnt == IDLE_LAST);
                // Priority: timeout, then mode change, then the increment.
                if (timeout) begin
                    state_next   = ST_RUN;
                    sec_clr_next = 1'b1;
                end else if (mode_press) begin
                    if (state == ST_SET_HR) begin
                        state_next = ST_SET_MIN;
                    end else begin
                        state_next   = ST_RUN;
                        sec_clr_next = 1'b1;
                    end
                end else if (inc_evt) begin
                    if (state == ST_SET_HR) begin
                        hr_inc_next = 1'b1;
                    end else begin
                        min_inc_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        hold_next = hold_cnt;
        idle_next = idle_cnt;
        if ((state == ST_RUN) || (state_next != state)) begin
            hold_next = '0;
            idle_next = '0;
        end else begin
            if (!inc_level) begin
                hold_next = '0;
            end else if (tick && (hold_cnt != HOLD_MAX)) begin
                hold_next = hold_cnt + 1'b1;
            end
            if (inc_evt) begin
                idle_next = '0;
            end else if (tick) begin
                idle_next = idle_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------ registered outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state    <= ST_RUN;
            hold_cnt <= '0;
            idle_cnt <= '0;
            sec_inc  <= 1'b0;
            min_inc  <= 1'b0;
            hr_inc   <= 1'b0;
            sec_clr  <= 1'b0;
        end else begin
            state    <= state_next;
            hold_cnt <= hold_next;
            idle_cnt <= idle_next;
            sec_inc  <= sec_inc_next;
            min_inc  <= min_inc_next;
            hr_inc   <= hr_inc_next;
            sec_clr  <= sec_clr_next;
        end
    end

    assign mode      = state;
    assign blink_hr  = (state == ST_SET_HR) & ~div_clk;
    assign blink_min = (state == ST_SET_MIN) & ~div_clk;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a history-based model.
module tb_clock_mode_ctrl;

    localparam int DB = 4;
    localparam int HT = 2;
    localparam int TT = 5;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       div_clk = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       sec_at_max = 1'b0;
    logic       min_at_max = 1'b0;
    logic       sec_inc;
    logic       min_inc;
    logic       hr_inc;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink_hr;
    logic       blink_min;

    clock_mode_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .HOLD_TICKS     (HT),
        .TIMEOUT_TICKS  (TT)
    ) dut (
        .clk_in    (clk_in),
        .reset     (reset),
        .div_clk   (div_clk),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .sec_at_max(sec_at_max),
        .min_at_max(min_at_max),
        .sec_inc   (sec_inc),
        .min_inc   (min_inc),
        .hr_inc    (hr_inc),
        .sec_clr   (sec_clr),
        .mode      (mode),
        .blink_hr  (blink_hr),
        .blink_min (blink_min)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    // ------------------------------------------------------------ model
    // The model keeps raw input histories: a div_clk rise seen at one edge is acted
    // on at the next, and a button level flips once the last DB synchronized
    // samples (two edges old and older) all disagree with it.
    logic [1:0] m_state;
    int         m_hold;
    int         m_idle;
    bit         m_sec, m_min, m_hr, m_clr;
    bit         model_valid = 1'b0;
    bit         div_hist [2];
    bit         btn_hist [2][DB+1];
    bit         lvl [2];
    bit         lvl_old [2];

    task automatic model_step();
        bit         tick;
        bit         flip;
        bit         rpt;
        bit         raw;
        bit         tmo;
        bit         press [2];
        bit         now [2];
        logic [1:0] nxt;
        now[0] = btn_mode;
        now[1] = btn_inc;
        if (reset) begin
            model_valid = 1'b1;
            m_state = 2'd0;
            m_hold = 0;
            m_idle = 0;
            m_sec = 1'b0;
            m_min = 1'b0;
            m_hr = 1'b0;
            m_clr = 1'b0;
            div_hist[0] = 1'b0;
            div_hist[1] = 1'b0;
            for (int b = 0; b < 2; b++) begin
                lvl[b] = 1'b0;
                lvl_old[b] = 1'b0;
                for (int i = 0; i <= DB; i++) btn_hist[b][i] = 1'b0;
            end
            return;
        end
        tick = div_hist[0] && !div_hist[1];
        for (int b = 0; b < 2; b++) press[b] = lvl[b] && !lvl_old[b];

        m_sec = 1'b0;
        m_min = 1'b0;
        m_hr = 1'b0;
        m_clr = 1'b0;
        nxt = m_state;
        raw = 1'b0;
        if (m_state == 2'd0) begin
            if (tick) begin
                m_sec = 1'b1;
                m_min = sec_at_max;
                m_hr = sec_at_max && min_at_max;
            end
            if (press[0]) nxt = 2'd1;
        end else begin
            rpt = tick && lvl[1] && (m_hold >= HT);
            raw = press[1] || rpt;
            tmo = tick && !raw && (m_idle + 1 >= TT);
            if (tmo) begin
                nxt = 2'd0;
                m_clr = 1'b1;
            end else if (press[0]) begin
                nxt = (m_state == 2'd1) ? 2'd2 : 2'd0;
                m_clr = (m_state == 2'd2);
            end else if (raw) begin
                if (m_state == 2'd1) m_hr = 1'b1;
                else m_min = 1'b1;
            end
        end
        if (m_state == 2'd0 || nxt != m_state) begin
            m_hold = 0;
            m_idle = 0;
        end else begin
            if (!lvl[1]) m_hold = 0;
            else if (tick) m_hold++;
            if (raw) m_idle = 0;
            else if (tick) m_idle++;
        end
        m_state = nxt;

        for (int b = 0; b < 2; b++) begin
            flip = 1'b1;
            for (int i = 1; i <= DB; i++) if (btn_hist[b][i] == lvl[b]) flip = 1'b0;
            lvl_old[b] = lvl[b];
            if (flip) lvl[b] = !lvl[b];
            for (int i = DB; i > 0; i--) btn_hist[b][i] = btn_hist[b][i-1];
            btn_hist[b][0] = now[b];
        end
        div_hist[1] = div_hist[0];
        div_hist[0] = div_clk;
    endtask

    always @(posedge clk_in) model_step();

    // ------------------------------------------------ stimulus helpers
    int step_no = 0;
    int rise_step = 0;
    int last_lat = -1;
    int div_cnt = 0;
    int div_half = 8;
    bit rand_div = 1'b0;
    int cnt_sec = 0, cnt_min = 0, cnt_hr = 0, cnt_clr = 0, cnt_all3 = 0;
    int cnt_bhr = 0, cnt_bmin = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // One clock: compare outputs on the falling edge, then move div_clk.
    task automatic step();
        logic [7:0] act_v;
        logic [7:0] exp_v;
        @(negedge clk_in);
        step_no++;
        if (model_valid) begin
            exp_v = {m_sec, m_min, m_hr, m_clr, m_state,
                     (m_state == 2'd1) && !div_clk, (m_state == 2'd2) && !div_clk};
            act_v = {sec_inc, min_inc, hr_inc, sec_clr, mode, blink_hr, blink_min};
            check("outputs_vs_model", 32'(act_v), 32'(exp_v));
        end
        cnt_sec += int'(sec_inc);
        cnt_min += int'(min_inc);
        cnt_hr += int'(hr_inc);
        cnt_clr += int'(sec_clr);
        cnt_all3 += int'(sec_inc & min_inc & hr_inc);
        cnt_bhr += int'(blink_hr);
        cnt_bmin += int'(blink_min);
        if (sec_inc) last_lat = step_no - rise_step;
        #1;
        div_cnt++;
        if (div_cnt >= div_half) begin
            div_cnt = 0;
            div_clk = !div_clk;
            if (div_clk) rise_step = step_no;
            if (rand_div) div_half = int'($urandom_range(1, 10));
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic press_btn(input bit which);
        if (which) btn_inc = 1'b1;
        else btn_mode = 1'b1;
        run(10);
        btn_inc = 1'b0;
        btn_mode = 1'b0;
        run(10);
    endtask

    // ------------------------------------------------------------ main
    initial begin
        int b_sec, b_min, b_hr, b_clr, b_all3, b_bhr, b_bmin;
        int n;
        int mode_left;
        int inc_left;

        run(3);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_pulses", 32'({sec_inc, min_inc, hr_inc, sec_clr}), 32'd0);
        check("reset_blink", 32'({blink_hr, blink_min}), 32'd0);
        reset = 1'b0;

        // Full carry: all three increments together, once per div_clk period.
        sec_at_max = 1'b1;
        min_at_max = 1'b1;
        b_sec = cnt_sec; b_min = cnt_min; b_hr = cnt_hr; b_all3 = cnt_all3;
        run(32);
        check("carry_sec", 32'(cnt_sec - b_sec), 32'd2);
        check("carry_min", 32'(cnt_min - b_min), 32'd2);
        check("carry_hr", 32'(cnt_hr - b_hr), 32'd2);
        check("carry_same_cycle", 32'(cnt_all3 - b_all3), 32'd2);
        check("tick_latency", 32'(last_lat), 32'd2);

        sec_at_max = 1'b0;
        b_sec = cnt_sec; b_min = cnt_min; b_hr = cnt_hr;
        run(32);
        check("nocarry_sec", 32'(cnt_sec - b_sec), 32'd2);
        check("nocarry_min", 32'(cnt_min - b_min), 32'd0);
        check("nocarry_hr", 32'(cnt_hr - b_hr), 32'd0);

        // Bouncing mode button must be rejected; a clean hold is accepted.
        for (int i = 0; i < 10; i++) begin
            btn_mode = !btn_mode;
            run(2);
        end
        check("bounce_rejected", 32'(mode), 32'd0);
        btn_mode = 1'b1;
        run(10);
        check("held_to_set_hr", 32'(mode), 32'd1);
        btn_mode = 1'b0;
        run(10);
        b_clr = cnt_clr;
        press_btn(1'b0);
        check("press_to_set_min", 32'(mode), 32'd2);
        press_btn(1'b0);
        check("press_to_run", 32'(mode), 32'd0);
        check("leave_set_min_clr", 32'(cnt_clr - b_clr), 32'd1);

        // Minutes set at 59: one increment, no carry, no time-base increments.
        press_btn(1'b0);
        press_btn(1'b0);
        check("enter_set_min", 32'(mode), 32'd2);
        sec_at_max = 1'b1;
        min_at_max = 1'b1;
        b_sec = cnt_sec; b_min = cnt_min; b_hr = cnt_hr;
        press_btn(1'b1);
        run(16);
        check("set_min_one_inc", 32'(cnt_min - b_min), 32'd1);
        check("set_min_no_hr", 32'(cnt_hr - b_hr), 32'd0);
        check("set_min_no_sec", 32'(cnt_sec - b_sec), 32'd0);
        press_btn(1'b0);
        check("back_to_run", 32'(mode), 32'd0);

        // Auto-repeat: six ticks of hold give one press plus four repeats.
        sec_at_max = 1'b0;
        min_at_max = 1'b0;
        press_btn(1'b0);
        check("enter_set_hr", 32'(mode), 32'd1);
        b_sec = cnt_sec; b_min = cnt_min; b_hr = cnt_hr;
        btn_inc = 1'b1;
        run(96);
        btn_inc = 1'b0;
        run(10);
        check("repeat_hr_count", 32'(cnt_hr - b_hr), 32'd5);
        check("repeat_no_min", 32'(cnt_min - b_min), 32'd0);
        check("repeat_no_sec", 32'(cnt_sec - b_sec), 32'd0);
        press_btn(1'b0);
        press_btn(1'b0);
        check("repeat_exit", 32'(mode), 32'd0);

        // Timeout out of SET_HR after five idle ticks.
        btn_mode = 1'b1;
        n = 0;
        while (mode != 2'd1 && n < 30) begin
            step();
            n++;
        end
        check("timeout_entered", 32'(mode), 32'd1);
        btn_mode = 1'b0;
        b_bhr = cnt_bhr; b_bmin = cnt_bmin;
        n = 0;
        while (mode != 2'd0 && n < 200) begin
            step();
            n++;
        end
        check("timeout_mode", 32'(mode), 32'd0);
        check("timeout_sec_clr", 32'(sec_clr), 32'd1);
        check("timeout_window", 32'(n >= 65 && n <= 80), 32'd1);
        check("blink_hr_seen", 32'(cnt_bhr - b_bhr > 0), 32'd1);
        check("blink_min_quiet", 32'(cnt_bmin - b_bmin), 32'd0);
        run(4);

        // Reset while in SET_MIN with the increment button held.
        press_btn(1'b0);
        press_btn(1'b0);
        check("pre_reset_set_min", 32'(mode), 32'd2);
        btn_inc = 1'b1;
        run(10);
        reset = 1'b1;
        run(1);
        reset = 1'b0;
        check("mid_reset_mode", 32'(mode), 32'd0);
        check("mid_reset_pulses", 32'({sec_inc, min_inc, hr_inc, sec_clr}), 32'd0);
        b_min = cnt_min; b_hr = cnt_hr;
        run(40);
        check("post_reset_no_min", 32'(cnt_min - b_min), 32'd0);
        check("post_reset_no_hr", 32'(cnt_hr - b_hr), 32'd0);
        check("post_reset_mode", 32'(mode), 32'd0);
        btn_inc = 1'b0;
        run(10);

        // Randomized run against the model.
        rand_div = 1'b1;
        mode_left = 0;
        inc_left = 0;
        for (int k = 0; k < 4000; k++) begin
            if (mode_left == 0) begin
                btn_mode = 1'($urandom_range(0, 1));
                mode_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                        : int'($urandom_range(20, 150));
            end else begin
                mode_left--;
            end
            if (inc_left == 0) begin
                btn_inc = 1'($urandom_range(0, 1));
                inc_left = ($urandom_range(0, 5) == 0) ? int'($urandom_range(40, 120))
                                                       : int'($urandom_range(1, 20));
            end else begin
                inc_left--;
            end
            sec_at_max = ($urandom_range(0, 3) == 0);
            min_at_max = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 599) == 0);
            step();
        end
        reset = 1'b0;
        btn_mode = 1'b0;
        btn_inc = 1'b0;
        run(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
